// File: rtl/watch_calendar.sv
// Calendar-date counter: advances year/month/day and day-of-week on a day tick,
// applies Gregorian leap rules, validates loads and emits month/year carry pulses.
module watch_calendar #(
    parameter int unsigned YEAR_W   = 12,
    parameter int unsigned YEAR_MIN = 1,
    parameter int unsigned YEAR_MAX = 2**YEAR_W - 1,
    parameter int unsigned LEAP_EN  = 1,
    parameter int unsigned DOW_RST  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_day,
    input  logic              set_date,
    input  logic [YEAR_W+8:0] bin_date,
    input  logic [2:0]        set_dow,
    output logic [YEAR_W-1:0] year,
    output logic [3:0]        month,
    output logic [4:0]        day,
    output logic [2:0]        dow,
    output logic              leap,
    output logic              month_end,
    output logic              year_end,
    output logic              set_err
);

    localparam logic [YEAR_W-1:0] YMIN_V = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] YMAX_V = YEAR_W'(YEAR_MAX);
    localparam logic [2:0]        DOW_RST_V = 3'(DOW_RST);

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        int unsigned v;
        v = 32'(y);
        return (LEAP_EN != 0) && ((v % 4) == 0) && (((v % 100) != 0) || ((v % 400) == 0));
    endfunction

    function automatic logic [4:0] days_in(input logic [3:0] m, input logic lp);
        case (m)
            4'd2:                      return lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    logic [YEAR_W-1:0] ld_year;
    logic [3:0]        ld_month;
    logic [4:0]        ld_day;
    logic              ld_ok;
    logic [4:0]        max_day;

    logic [YEAR_W-1:0] year_n;
    logic [3:0]        month_n;
    logic [4:0]        day_n;
    logic [2:0]        dow_n;
    logic              month_end_n;
    logic              year_end_n;
    logic              set_err_n;

    assign ld_year  = bin_date[YEAR_W+8:9];
    assign ld_month = bin_date[8:5];
    assign ld_day   = bin_date[4:0];

    assign leap    = is_leap(year);
    assign max_day = days_in(month, leap);

    // Load validation uses the month length of the loaded date, not the current one.
    assign ld_ok = (ld_year >= YMIN_V) && (ld_year <= YMAX_V)
                && (ld_month >= 4'd1) && (ld_month <= 4'd12)
                && (ld_day >= 5'd1) && (ld_day <= days_in(ld_month, is_leap(ld_year)))
                && (set_dow <= 3'd6);

    always_comb begin
        year_n      = year;
        month_n     = month;
        day_n       = day;
        dow_n       = dow;
        month_end_n = 1'b0;
        year_end_n  = 1'b0;
        set_err_n   = 1'b0;
        if (set_date) begin
            if (ld_ok) begin
                year_n  = ld_year;
                month_n = ld_month;
                day_n   = ld_day;
                dow_n   = set_dow;
            end else begin
                set_err_n = 1'b1;
            end
        end else if (en_day) begin
            dow_n = (dow == 3'd6) ? 3'd0 : dow + 3'd1;
            if (day < max_day) begin
                day_n = day + 5'd1;
            end else begin
                day_n       = 5'd1;
                month_end_n = 1'b1;
                if (month < 4'd12) begin
                    month_n = month + 4'd1;
                end else begin
                    month_n    = 4'd1;
                    year_end_n = 1'b1;
                    year_n     = (year < YMAX_V) ? year + YEAR_W'(1) : YMIN_V;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            year      <= YMIN_V;
            month     <= 4'd1;
            day       <= 5'd1;
            dow       <= DOW_RST_V;
            month_end <= 1'b0;
            year_end  <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            year      <= year_n;
            month     <= month_n;
            day       <= day_n;
            dow       <= dow_n;
            month_end <= month_end_n;
            year_end  <= year_end_n;
            set_err   <= set_err_n;
        end
    end

endmodule

// File: doc/watch_calendar.md
# watch_calendar

Parametrised calendar-date counter for the watch datapath, next generation of the date block. It advances a year/month/day register on a one-cycle day-tick from the time-of-day counter. It applies full Gregorian leap-year rules and tracks day-of-week. It validates software/keypad loads and emits month and year carry pulses for the alarm and display blocks.

## Interface
Parameters:
- YEAR_W, 12, width of the year field.
- YEAR_MIN, 1, lowest legal year; reset and wrap target.
- YEAR_MAX, 2**YEAR_W-1, highest legal year; must satisfy YEAR_MIN <= YEAR_MAX < 2**YEAR_W.
- LEAP_EN, 1, 1 = Gregorian leap rule, 0 = February is always 28 days.
- DOW_RST, 0, day-of-week value at reset, 0..6 (0 = Sunday).

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- en_day  in  1  one-cycle day-advance tick.
- set_date  in  1  load request, one cycle.
- bin_date  in  YEAR_W+9  load value {year[YEAR_W-1:0], month[3:0], day[4:0]}.
- set_dow  in  3  day-of-week loaded with set_date.
- year  out  YEAR_W  current year.
- month  out  4  current month, 1..12.
- day  out  5  current day, 1..31.
- dow  out  3  current day-of-week, 0..6.
- leap  out  1  combinational; 1 when the current year is a leap year.
- month_end  out  1  registered one-cycle pulse on a month rollover.
- year_end  out  1  registered one-cycle pulse on a year rollover, including the YEAR_MAX wrap.
- set_err  out  1  registered one-cycle pulse when a load is rejected.

## Operation
- Leap year: year%4==0 and (year%100!=0 or year%400==0), gated by LEAP_EN. Computed combinationally on the current year.
- max_day: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 29 for February in a leap year, else 28.
- Advance when en_day=1 and set_date=0:
  - day<max_day: day+1.
  - day==max_day and month<12: month+1, day=1, month_end pulse.
  - day==max_day and month==12 and year<YEAR_MAX: year+1, month=1, day=1, month_end and year_end pulse.
  - day==max_day, month==12, year==YEAR_MAX: year=YEAR_MIN, month=1, day=1, month_end and year_end pulse.
  - Every advance: dow=(dow==6)?0:dow+1.
- Load when set_date=1 (takes priority over en_day; en_day in the same cycle is dropped):
  - A load is valid when all hold: YEAR_MIN<=year<=YEAR_MAX; month 1..12; 1<=day<=max_day, with max_day computed for the loaded month and year; set_dow<=6.
  - Valid load: all four fields take the load values; no carry pulses.
  - Invalid load: state is unchanged and set_err pulses.
- Idle (en_day=0, set_date=0): all state holds; pulses are 0.
- Counter state is always a legal date; no illegal-state recovery is required beyond reset.

## Timing
- Reset values: year=YEAR_MIN, month=1, day=1, dow=DOW_RST, month_end=0, year_end=0, set_err=0. rst may assert at any cycle, including mid-rollover; outputs return to reset values immediately (asynchronous).
- Latency: 1 cycle. State and pulses update on the clk edge that samples en_day or set_date high. Pulses are high for exactly the following cycle.
- en_day held high for N cycles gives N advances; no minimum spacing.
- leap and max_day follow the registered year/month combinationally.

## Test plan
- Reset, then 31 en_day ticks -> 0001-02-01, dow=(DOW_RST+31)%7=3, month_end pulsed once.
- Load 2024-02-28, two ticks -> 2024-02-29, then 2024-03-01; leap=1. Load 2100-02-28, one tick -> 2100-03-01, leap=0. Load 2000-02-29 -> accepted.
- Load 2023-02-29, month 13, day 0, or year 0 -> set_err one cycle, state unchanged.
- Load 4095-12-31, tick -> 0001-01-01, month_end=year_end=1 for one cycle. Load 2023-12-31, tick -> 2024-01-01.
- set_date and en_day in the same cycle with load 2024-06-15 -> 2024-06-15 exactly, no advance.
- Assert rst the cycle a month rollover is taken -> reset values, no pulse afterwards.
